// File: rtl/rr_trace_wb_scheduler.sv
// rtl/rr_trace_wb_scheduler.sv - AXI4 write-back scheduler draining trace beats into a circular DRAM buffer
module rr_trace_wb_scheduler #(
  parameter int AXI_WIDTH       = 512,
  parameter int OFFSET_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      sync_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_size,
  input  logic                      cfg_start,
  input  logic [AXI_WIDTH-1:0]      fifo_dout,
  input  logic [OFFSET_WIDTH-1:0]   fifo_dout_size,
  input  logic [OFFSET_WIDTH-1:0]   fifo_count,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic                      finish_req,
  output logic                      finish_done,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_WIDTH-1:0]      wdata,
  output logic [AXI_WIDTH/8-1:0]    wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ADDR_WIDTH-1:0] wr_off,
  output logic [63:0]               total_bytes,
  output logic [31:0]               wrap_cnt,
  output logic                      err
);

  localparam int STRB_W     = AXI_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(STRB_W);
  localparam int PAGE_BEATS = 4096 / STRB_W;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT_B, S_DONE} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] cfg_base_q;
  logic [AXI_ADDR_WIDTH-1:0] cfg_size_q;
  logic [OUT_W-1:0]          outstanding;
  logic                      finish_pending;
  logic [7:0]                beat_cnt;

  logic [AXI_ADDR_WIDTH-1:0] page_beats;
  logic [AXI_ADDR_WIDTH-1:0] end_beats;
  logic [AXI_ADDR_WIDTH-1:0] len_wide;
  logic [8:0]                burst_len;
  logic [AXI_ADDR_WIDTH-1:0] wr_off_next;
  logic [OFFSET_WIDTH-1:0]   beat_bytes;
  logic                      count_ok;
  logic                      burst_go;
  logic                      aw_fire;
  logic                      w_fire;
  logic                      b_fire;
  logic                      unused_bits;

  assign awsize  = 3'(BEAT_SHIFT);
  assign awburst = 2'b01;

  // Write channel streams the FIFO head straight through while a burst is open
  assign wvalid     = (state == S_DATA) && !fifo_empty;
  assign wdata      = fifo_dout;
  assign wlast      = (state == S_DATA) && (beat_cnt == awlen);
  assign fifo_rd_en = wvalid && wready;
  assign beat_bytes = {3'b000, fifo_dout_size[OFFSET_WIDTH-1:3]};

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign b_fire  = bvalid && bready;

  assign unused_bits = ^{fifo_dout_size[2:0], len_wide[AXI_ADDR_WIDTH-1:9]};

  // Byte strobes cover only the valid bytes of a possibly partial beat
  always_comb begin
    wstrb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wstrb[i] = (OFFSET_WIDTH'(i) < beat_bytes);
    end
  end

  // Burst length: limited by burst cap, queued beats, 4 KB page and buffer end
  always_comb begin
    page_beats = AXI_ADDR_WIDTH'(PAGE_BEATS) - AXI_ADDR_WIDTH'(wr_off[11:BEAT_SHIFT]);
    end_beats  = (cfg_size_q - wr_off) >> BEAT_SHIFT;
    len_wide   = AXI_ADDR_WIDTH'(MAX_BURST);
    if (AXI_ADDR_WIDTH'(fifo_count) < len_wide) len_wide = AXI_ADDR_WIDTH'(fifo_count);
    if (page_beats < len_wide) len_wide = page_beats;
    if (end_beats < len_wide) len_wide = end_beats;
    burst_len   = len_wide[8:0];
    wr_off_next = wr_off + (AXI_ADDR_WIDTH'(burst_len) << BEAT_SHIFT);
    count_ok    = (fifo_count >= OFFSET_WIDTH'(MAX_BURST)) ||
                  (finish_pending && (fifo_count != '0));
    burst_go    = (outstanding < OUT_W'(MAX_OUTSTANDING)) && count_ok && (burst_len != '0);
  end

  // Main sequencer: burst issue, data beats, B accounting and the finish handshake
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state          <= S_IDLE;
      cfg_base_q     <= '0;
      cfg_size_q     <= '0;
      outstanding    <= '0;
      finish_pending <= 1'b0;
      beat_cnt       <= '0;
      awaddr         <= '0;
      awlen          <= '0;
      awvalid        <= 1'b0;
      bready         <= 1'b0;
      finish_done    <= 1'b0;
      err            <= 1'b0;
      wr_off         <= '0;
      total_bytes    <= '0;
      wrap_cnt       <= '0;
    end else begin
      bready      <= 1'b1;
      outstanding <= outstanding + OUT_W'(aw_fire) - OUT_W'(b_fire);
      if (finish_req) finish_pending <= 1'b1;
      if (b_fire && (bresp != 2'b00)) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            cfg_base_q     <= cfg_base;
            cfg_size_q     <= cfg_size;
            wr_off         <= '0;
            total_bytes    <= '0;
            wrap_cnt       <= '0;
            finish_pending <= 1'b0;
          end else if (burst_go) begin
            awaddr  <= cfg_base_q + wr_off;
            awlen   <= 8'(burst_len - 9'd1);
            awvalid <= 1'b1;
            state   <= S_ADDR;
            if (wr_off_next >= cfg_size_q) begin
              wr_off   <= '0;
              wrap_cnt <= wrap_cnt + 32'd1;
            end else begin
              wr_off <= wr_off_next;
            end
          end else if (finish_pending && fifo_empty && (outstanding == '0)) begin
            state <= S_WAIT_B;
          end
        end
        S_ADDR: begin
          if (awready) begin
            awvalid  <= 1'b0;
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            total_bytes <= total_bytes + 64'(beat_bytes);
            if (beat_cnt == awlen) begin
              state <= S_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_WAIT_B: begin
          if ((outstanding == '0) && !bvalid) begin
            state          <= S_DONE;
            finish_done    <= 1'b1;
            finish_pending <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (cfg_start) begin
            cfg_base_q     <= cfg_base;
            cfg_size_q     <= cfg_size;
            wr_off         <= '0;
            total_bytes    <= '0;
            wrap_cnt       <= '0;
            finish_pending <= 1'b0;
            finish_done    <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_trace_wb_scheduler.sv
// tb/tb_rr_trace_wb_scheduler.sv - directed self-checking bench for rr_trace_wb_scheduler
module tb_rr_trace_wb_scheduler;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic [63:0]   cfg_base, cfg_size;
  logic          cfg_start;
  logic [511:0]  fifo_dout;
  logic [31:0]   fifo_dout_size, fifo_count;
  logic          fifo_empty, fifo_rd_en;
  logic          finish_req, finish_done;
  logic [63:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready;
  logic [511:0]  wdata;
  logic [63:0]   wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [63:0]   wr_off, total_bytes;
  logic [31:0]   wrap_cnt;
  logic          err;

  always #5 clk = ~clk;

  rr_trace_wb_scheduler dut (
    .clk(clk), .sync_rst(sync_rst),
    .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_start(cfg_start),
    .fifo_dout(fifo_dout), .fifo_dout_size(fifo_dout_size), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .finish_req(finish_req), .finish_done(finish_done),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_off(wr_off), .total_bytes(total_bytes), .wrap_cnt(wrap_cnt), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] fq_data[$];
  int unsigned  fq_size[$];
  logic [63:0]  aw_addr_q[$];
  logic [63:0]  aw_len_q[$];
  int           w_tag_q[$];
  logic [63:0]  w_strb_q[$];
  int           next_tag = 0;
  int           b_pending = 0;
  int           b_idx = 0;
  int           err_burst = -1;
  bit           auto_b = 1'b1;
  bit           w_toggle = 1'b0;
  int           first;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_count = 32'(fq_data.size());
    fifo_empty = (fq_data.size() == 0);
    if (fq_data.size() != 0) begin
      fifo_dout      = fq_data[0];
      fifo_dout_size = fq_size[0];
    end else begin
      fifo_dout      = '0;
      fifo_dout_size = 32'd512;
    end
  endtask

  task automatic push_beats(input int n, input int unsigned bits);
    logic [511:0] d;
    for (int i = 0; i < n; i++) begin
      d = '0;
      d[31:0]    = 32'(next_tag);
      d[511:480] = ~32'(next_tag);
      fq_data.push_back(d);
      fq_size.push_back(bits);
      next_tag++;
    end
    update_fifo();
  endtask

  // One clock: handshakes are sampled at the falling edge, models advance just after the rising edge
  task automatic tick();
    bit pop, aw_hs, w_hs, b_hs, wl;
    logic [63:0] a_addr, a_len, strb;
    logic [511:0] dd;
    int unsigned ds;
    int tag;
    @(negedge clk);
    pop    = fifo_rd_en;
    aw_hs  = awvalid && awready;
    w_hs   = wvalid && wready;
    wl     = wlast;
    b_hs   = bvalid && bready;
    a_addr = awaddr;
    a_len  = 64'(awlen);
    strb   = wstrb;
    tag    = int'(wdata[31:0]);
    @(posedge clk);
    #1;
    if (pop && fq_data.size() != 0) begin
      dd = fq_data.pop_front();
      ds = fq_size.pop_front();
    end
    if (aw_hs) begin
      aw_addr_q.push_back(a_addr);
      aw_len_q.push_back(a_len);
    end
    if (w_hs) begin
      w_tag_q.push_back(tag);
      w_strb_q.push_back(strb);
      if (wl) b_pending++;
    end
    if (b_hs) begin
      b_pending--;
      b_idx++;
    end
    bvalid = auto_b && (b_pending > 0);
    bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
    if (w_toggle) wready = ~wready;
    update_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_tag_q.delete();
    w_strb_q.delete();
    b_idx = 0;
  endtask

  task automatic start_cfg(input logic [63:0] base, input logic [63:0] size);
    cfg_base  = base;
    cfg_size  = size;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_finish();
    finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
  endtask

  task automatic wait_aw(input string tag, input int n, input int budget);
    int k = 0;
    while (aw_addr_q.size() < n && k < budget) begin tick(); k++; end
    check_eq(tag, 64'(aw_addr_q.size()), 64'(n));
  endtask

  task automatic wait_w(input string tag, input int n, input int budget);
    int k = 0;
    while (w_tag_q.size() < n && k < budget) begin tick(); k++; end
    check_eq(tag, 64'(w_tag_q.size()), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!finish_done && k < budget) begin tick(); k++; end
    check_eq(tag, 64'(finish_done), 64'd1);
  endtask

  task automatic check_aw(input string tag, input int idx, input logic [63:0] addr, input logic [63:0] len);
    if (idx < aw_addr_q.size()) begin
      check_eq({tag, "_addr"}, aw_addr_q[idx], addr);
      check_eq({tag, "_len"}, aw_len_q[idx], len);
    end else begin
      check_eq({tag, "_present"}, 64'(aw_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_order(input string tag, input int first_tag, input int n);
    int bad = 0;
    for (int i = 0; i < w_tag_q.size(); i++) if (w_tag_q[i] != first_tag + i) bad++;
    check_eq({tag, "_wcnt"}, 64'(w_tag_q.size()), 64'(n));
    check_eq({tag, "_word"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sync_rst = 1'b1; cfg_base = '0; cfg_size = '0; cfg_start = 1'b0; finish_req = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    update_fifo();
    tick(); tick();
    check_eq("rst_awvalid", awvalid, 0);
    check_eq("rst_wvalid", wvalid, 0);
    check_eq("rst_wlast", wlast, 0);
    check_eq("rst_rd_en", fifo_rd_en, 0);
    check_eq("rst_bready", bready, 0);
    check_eq("rst_done", finish_done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wr_off", wr_off, 0);
    check_eq("rst_total", total_bytes, 0);
    check_eq("rst_wrap", wrap_cnt, 0);
    check_eq("const_awsize", awsize, 6);
    check_eq("const_awburst", awburst, 1);
    sync_rst = 1'b0;
    tick();
    check_eq("bready_up", bready, 1);

    // Burst formation with an ignored mid-burst cfg_start
    start_cfg(64'h1000, 64'h2000);
    first = next_tag;
    push_beats(40, 512);
    wait_aw("t1_aw1", 1, 20);
    cfg_base = 64'h5000; cfg_start = 1'b1; tick(); cfg_start = 1'b0; cfg_base = 64'h1000;
    run(80);
    check_eq("t1_aw_cnt_mid", 64'(aw_addr_q.size()), 2);
    check_eq("t1_fifo_held", 64'(fq_data.size()), 8);
    check_eq("t1_wr_off_mid", wr_off, 64'h800);
    pulse_finish();
    wait_done("t1_done", 100);
    check_aw("t1_b0", 0, 64'h1000, 15);
    check_aw("t1_b1", 1, 64'h1400, 15);
    check_aw("t1_b2", 2, 64'h1800, 7);
    check_order("t1", first, 40);
    check_eq("t1_total", total_bytes, 2560);
    check_eq("t1_wr_off", wr_off, 64'hA00);
    check_eq("t1_wrap", wrap_cnt, 0);

    // 4 KB page split at wr_off 0xFC0
    start_cfg(64'h1000, 64'h2000);
    first = next_tag;
    push_beats(63, 512);
    pulse_finish();
    wait_aw("t2_aw4", 4, 200);
    push_beats(16, 512);
    wait_done("t2_done", 300);
    check_aw("t2_b3", 3, 64'h1C00, 14);
    check_aw("t2_pg0", 4, 64'h1FC0, 0);
    check_aw("t2_pg1", 5, 64'h2000, 14);
    check_eq("t2_aw_cnt", 64'(aw_addr_q.size()), 6);
    check_order("t2", first, 79);
    check_eq("t2_wr_off", wr_off, 64'h13C0);

    // Buffer-end split and wrap at wr_off cfg_size-128
    start_cfg(64'h10000, 64'h1000);
    first = next_tag;
    push_beats(62, 512);
    pulse_finish();
    wait_aw("t3_aw4", 4, 200);
    push_beats(16, 512);
    wait_done("t3_done", 300);
    check_aw("t3_b3", 3, 64'h10C00, 13);
    check_aw("t3_end", 4, 64'h10F80, 1);
    check_aw("t3_wrap", 5, 64'h10000, 13);
    check_eq("t3_wrap_cnt", wrap_cnt, 1);
    check_eq("t3_wr_off", wr_off, 64'h380);
    check_eq("t3_total", total_bytes, 64'd4992);
    check_order("t3", first, 78);

    // Partial last beat
    start_cfg(64'h20000, 64'h10000);
    first = next_tag;
    push_beats(1, 512);
    push_beats(1, 200);
    pulse_finish();
    wait_done("t4_done", 100);
    check_aw("t4_b0", 0, 64'h20000, 1);
    check_order("t4", first, 2);
    if (w_strb_q.size() >= 2) begin
      check_eq("t4_strb_full", w_strb_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("t4_strb_part", w_strb_q[1], 64'h1FF_FFFF);
    end
    check_eq("t4_total", total_bytes, 89);
    check_eq("t4_wr_off", wr_off, 128);

    // Outstanding limit
    start_cfg(64'h0, 64'h100000);
    auto_b = 1'b0;
    first = next_tag;
    push_beats(80, 512);
    run(150);
    check_eq("t5_aw_cap", 64'(aw_addr_q.size()), 4);
    check_eq("t5_awvalid_low", awvalid, 0);
    check_eq("t5_fifo_left", 64'(fq_data.size()), 16);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    check_eq("t5_aw_not_yet", awvalid, 0);
    tick();
    check_eq("t5_aw_5th", awvalid, 1);
    check_eq("t5_aw_5th_addr", awaddr, 64'h1000);
    check_eq("t5_aw_5th_len", awlen, 15);
    auto_b = 1'b1;
    pulse_finish();
    wait_done("t5_done", 300);
    check_eq("t5_aw_cnt", 64'(aw_addr_q.size()), 5);
    check_order("t5", first, 80);

    // Error response with W backpressure
    start_cfg(64'h40000, 64'h8000);
    err_burst = 1;
    w_toggle = 1'b1;
    first = next_tag;
    push_beats(32, 512);
    pulse_finish();
    wait_done("t6_done", 400);
    w_toggle = 1'b0; wready = 1'b1;
    check_aw("t6_b1", 1, 64'h40400, 15);
    check_order("t6", first, 32);
    check_eq("t6_err", err, 1);
    check_eq("t6_total", total_bytes, 2048);
    run(5);
    check_eq("t6_err_sticky", err, 1);
    err_burst = -1;

    // Reset in the middle of a burst
    start_cfg(64'h80000, 64'h10000);
    push_beats(32, 512);
    wait_w("t7_w4", 4, 100);
    sync_rst = 1'b1;
    tick();
    check_eq("t7_awvalid", awvalid, 0);
    check_eq("t7_wvalid", wvalid, 0);
    check_eq("t7_wlast", wlast, 0);
    check_eq("t7_rd_en", fifo_rd_en, 0);
    check_eq("t7_bready", bready, 0);
    check_eq("t7_total", total_bytes, 0);
    check_eq("t7_wr_off", wr_off, 0);
    check_eq("t7_err", err, 0);
    fq_data.delete(); fq_size.delete();
    b_pending = 0; bvalid = 1'b0;
    update_fifo();
    tick();
    sync_rst = 1'b0;
    tick();
    start_cfg(64'h90000, 64'h10000);
    first = next_tag;
    push_beats(16, 512);
    wait_aw("t7_aw1", 1, 20);
    check_aw("t7_fresh", 0, 64'h90000, 15);
    pulse_finish();
    wait_done("t7_done", 100);
    check_order("t7", first, 16);
    check_eq("t7_total_after", total_bytes, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_trace_wb_scheduler.md
# rr_trace_wb_scheduler

Write-back scheduler between the trace merger's 512-bit output FIFO and the DRAM AXI4 write port. It drains whole beats into AXI write bursts aimed at a circular trace buffer `[cfg_base, cfg_base+cfg_size)`. Bursts never cross a 4 KB page or the buffer end. The block bounds the number of outstanding bursts, tracks pointers and statistics, and sequences the end-of-record flush handshake.

## Interface
- AXI_WIDTH, 512, data beat width in bits.
- OFFSET_WIDTH, 32, width of the size and count fields.
- AXI_ADDR_WIDTH, 64, address width.
- MAX_BURST, 16, maximum beats per burst (≤256).
- MAX_OUTSTANDING, 4, maximum number of AW issued without a matching B.
- clk  in  1  clock.
- sync_rst  in  1  reset; synchronous, active-high.
- cfg_base  in  AXI_ADDR_WIDTH  buffer base; 4 KB aligned.
- cfg_size  in  AXI_ADDR_WIDTH  buffer size in bytes; a multiple of 4096 and nonzero.
- cfg_start  in  1  pulse; load the config and clear the pointers and statistics. Honoured in IDLE or DONE only.
- fifo_dout  in  AXI_WIDTH  head beat of a first-word-fall-through FIFO.
- fifo_dout_size  in  OFFSET_WIDTH  valid bits in the head beat: a multiple of 8, 1..AXI_WIDTH.
- fifo_count  in  OFFSET_WIDTH  beats currently in the FIFO.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pop the head beat.
- finish_req  in  1  pulse; the merger has issued its final flush.
- finish_done  out  1  all trace data is acknowledged by DRAM.
- awaddr  out  AXI_ADDR_WIDTH.
- awlen  out  8.
- awsize  out  3; constant log2(AXI_WIDTH/8).
- awburst  out  2; constant INCR.
- awvalid  out  1.
- awready  in  1.
- wdata  out  AXI_WIDTH.
- wstrb  out  AXI_WIDTH/8.
- wlast  out  1.
- wvalid  out  1.
- wready  in  1.
- bresp  in  2.
- bvalid  in  1.
- bready  out  1.
- wr_off  out  AXI_ADDR_WIDTH  next write offset from cfg_base.
- total_bytes  out  64  valid bytes written.
- wrap_cnt  out  32  number of buffer wraps.
- err  out  1  sticky; set by any bresp ≠ OKAY.

## Operation
- The state machine has five states: IDLE, ADDR, DATA, WAIT_B, DONE.
- IDLE computes a burst when all of the following hold:
  - outstanding < MAX_OUTSTANDING;
  - fifo_count ≥ MAX_BURST, or finish_pending=1 with fifo_count > 0.
- Burst length is len = min(MAX_BURST, fifo_count, beats to the next 4 KB boundary, beats to the buffer end).
- On a burst decision:
  - latch awaddr = cfg_base + wr_off and awlen = len−1;
  - advance wr_off by len·64, wrapping to 0 (and incrementing wrap_cnt) when it reaches cfg_size;
  - go to ADDR.
- ADDR: hold awvalid=1 until awready. On the handshake, outstanding++ and go to DATA.
- DATA:
  - wvalid = ~fifo_empty; wdata = fifo_dout; fifo_rd_en = wvalid & wready.
  - wstrb has its low fifo_dout_size/8 bits set.
  - total_bytes += fifo_dout_size/8 on each accepted beat.
  - wlast is asserted on beat len−1. After the last beat is accepted, return to IDLE.
- B channel: bready=1 whenever the block is out of reset. Each bvalid decrements outstanding. A nonzero bresp sets err.
- finish_req sets finish_pending.
- IDLE with finish_pending=1, fifo_empty=1 and outstanding=0 goes to WAIT_B→DONE. DONE sets finish_done=1 and clears finish_pending.
- DONE holds until cfg_start, which returns the block to IDLE.
- WAIT_B is one cycle: it confirms outstanding=0 with no bvalid.
- The address always advances by whole 64 B beats, including for a partial last beat.

## Timing
- Reset values: awvalid=0, wvalid=0, wlast=0, fifo_rd_en=0, bready=0, finish_done=0, err=0, wr_off=0, total_bytes=0, wrap_cnt=0, outstanding=0, finish_pending=0, state=IDLE.
- Reset applied mid-burst abandons the burst immediately; the AXI valids drop on the next edge.
- AW latency: awvalid rises 1 cycle after the IDLE decision cycle.
- wvalid may rise in the cycle after the AW handshake.
- A beat is accepted in the same cycle as the W handshake; data is never consumed before AW completes.
- A simultaneous AW handshake and bvalid leaves outstanding unchanged.
- fifo_count is sampled once per burst. The upstream FIFO never loses beats, so DATA never starves by more than transient empty cycles.
- A finish_req arriving while in DATA is latched and takes effect at the next IDLE.
- A cfg_start outside IDLE or DONE is ignored.

## Test plan
- **Burst formation:** cfg_base=0x1000, cfg_size=0x2000, 40 full beats, always-ready slave -> bursts at 0x1000/0x1400/0x1800 with awlen=15,15 and the last 8 beats held in the FIFO until finish_req; then an awlen=7 burst at 0x1800 and finish_done.
- **4 KB and buffer-end split:** wr_off=0xFC0, 16 beats queued -> awlen=0 at base+0xFC0, then awlen=14 at base+0x1000. Separately, wr_off=cfg_size−128 -> awlen=1, wr_off wraps to 0, wrap_cnt=1.
- **Partial last beat:** final beat with size=200 bits -> wstrb=0x1FFFFFF (25 bytes), total_bytes increases by 25, wr_off increases by 64.
- **Outstanding limit:** bvalid held 0 -> exactly 4 AW handshakes, then awvalid stays 0. Release one B -> a 5th AW is issued the cycle after the IDLE decision.
- **Error and backpressure:** wready toggled 50%, bresp=SLVERR on the 2nd burst -> wdata order preserved, err=1 sticky, finish_done is still reached.
- **Reset mid-burst:** sync_rst asserted in DATA beat 5 -> next cycle all valids=0, counters=0, state=IDLE; after cfg_start, a fresh burst starts at cfg_base.
